mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
Controller that sequences one MAC_Core through a layer of N_NEURONS dot products of N_INPUTS terms each. It reads weights and inputs from external synchronous-read memories and streams them into the MAC. It drives the MAC's forget, oe and reset lines and captures each neuron's 8-bit result with an index and a valid strobe. It sits between the layer memories and the MAC and is started by a start pulse from the upper-level control.

Parameters:
N_INPUTS, 4, terms per dot product (>=2)
N_NEURONS, 2, dot products per run (>=1)
X_ADDR_W, 2, input-memory address width, >= clog2(N_INPUTS)
W_ADDR_W, 3, weight-memory address width, >= clog2(N_INPUTS*N_NEURONS)
IDX_W, 1, neuron index width, >= max(1, clog2(N_NEURONS))

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle run request; sampled in IDLE only
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last result is captured
rd_en  out  1  memory read enable
w_addr  out  W_ADDR_W  weight address = neuron*N_INPUTS + i
x_addr  out  X_ADDR_W  input address = i
w_rdata  in  8  weight data, valid 1 cycle after rd_en
x_rdata  in  8  input data, valid 1 cycle after rd_en
mac_weight  out  8  to MAC weight; w_rdata when the data is valid, else 0
mac_in  out  8  to MAC in; x_rdata when the data is valid, else 0
mac_forget  out  1  to MAC forget
mac_oe  out  1  to MAC oe
mac_reset  out  1  to MAC reset (active high)
mac_out  in  8  from MAC out
result  out  8  captured accumulator value
result_idx  out  IDX_W  neuron index of result
result_valid  out  1  one-cycle pulse when result/result_idx update

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, counters 0, rd_en/mac_forget/mac_oe/busy/done/result_valid = 0, result = 0, result_idx = 0, mac_reset = 1, and the data-valid pipeline flags are cleared. Reset mid-run aborts the run. There is no partial result and no done pulse.
- States: IDLE, FETCH, DRAIN, READ, DONE. All control outputs are registered except mac_weight and mac_in, which are data muxes gated by a registered valid flag.
- IDLE: mac_reset = 1. If start=1, go to FETCH with i=0 and neuron=0, and set busy=1 from the next cycle. mac_reset = 0 in every other state.
- FETCH: lasts N_INPUTS cycles (t0..t0+N-1). rd_en=1, address i, i increments each cycle. After i = N-1, go to DRAIN.
- Data valid flag v1 = rd_en delayed 1 cycle. mac_weight/mac_in carry pair i in cycle t0+1+i and are 0 otherwise. Zero-forcing is mandatory: the MAC accumulates every cycle, and zero products hold the accumulator.
- mac_forget = 1 for exactly the cycle t0+2, when the MAC's internal registers hold pair 0. This makes the accumulator = w0*x0 at the end of t0+2 and discards the previous neuron's sum.
- DRAIN: cycles t0+N and t0+N+1, waiting for the final product to land. The accumulator is valid in t0+N+2.
- READ: cycle t0+N+2. mac_oe=1. result <= mac_out and result_idx <= neuron at the end of the cycle, so result_valid=1 in t0+N+3. If neuron < N_NEURONS-1: neuron++, i=0, go to FETCH (next t0 = t0+N+3). Otherwise go to DONE.
- Per-neuron latency is N_INPUTS+3 cycles. There is no overlap between neurons.
- DONE: one cycle. done=1 and busy=0 in the following cycle, then return to IDLE. done coincides with the last result_valid.
- start while not in IDLE is ignored.
- Arithmetic is performed by the MAC modulo 256 (8-bit product and sum wrap). The sequencer passes the value through unchanged.
- Addresses never exceed N_INPUTS*N_NEURONS-1. The counters wrap to 0 at the end of a run.

Test Plan:
- N=4, 1 neuron: weights 1,2,3,4, inputs 5,6,7,8, start -> result=70, result_idx=0, result_valid exactly 7 cycles after the first FETCH cycle, done on the same cycle.
- 2 neurons: weights {1,2,3,4} and {2,2,2,2}, inputs 5,6,7,8 -> results 70 (idx 0) then 52 (idx 1), 7 cycles apart. Proves forget clears the old sum.
- Wrap: all weights 20, all inputs 20 -> product 400 mod 256 = 144 per term, result = 576 mod 256 = 64.
- Post-run hold: after done, keep w_rdata/x_rdata = 0xFF with rd_en=0 -> mac_weight = mac_in = 0; a second run with weights 1,1,1,1 and inputs 1,1,1,1 gives result=4.
- start re-pulsed during FETCH and READ -> ignored: exactly N_NEURONS result_valid pulses and one done.
- reset=0 asserted mid-FETCH of neuron 1 -> outputs at reset values immediately (mac_reset=1, rd_en=0, busy=0), no done; a new start after release gives the correct results from neuron 0.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: steps one MAC through N_NEURONS dot products of N_INPUTS terms,
// fetching weights/inputs from synchronous-read memories and capturing each result.
module mac_sequencer #(
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 2,
    parameter int X_ADDR_W  = 2,
    parameter int W_ADDR_W  = 3,
    parameter int IDX_W     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic [X_ADDR_W-1:0] x_addr,
    input  logic [7:0]          w_rdata,
    input  logic [7:0]          x_rdata,
    output logic [7:0]          mac_weight,
    output logic [7:0]          mac_in,
    output logic                mac_forget,
    output logic                mac_oe,
    output logic                mac_reset,
    input  logic [7:0]          mac_out,
    output logic [7:0]          result,
    output logic [IDX_W-1:0]    result_idx,
    output logic                result_valid
);
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, READ, DONE} state_t;
    state_t state, next_state;
    logic [IDX_W-1:0] neuron;
    logic drain, v1, v2, last_i, last_n;
    assign last_i = x_addr == X_ADDR_W'(N_INPUTS - 1);
    assign last_n = neuron == IDX_W'(N_NEURONS - 1);
    // Zero-forced data keeps the free-running MAC accumulator still between pairs
    assign mac_weight = v1 ? w_rdata : 8'd0;
    assign mac_in     = v1 ? x_rdata : 8'd0;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? FETCH : IDLE;
            FETCH:   next_state = last_i ? DRAIN : FETCH;
            DRAIN:   next_state = drain ? READ : DRAIN;
            READ:    next_state = last_n ? DONE : FETCH;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            x_addr       <= '0;
            w_addr       <= '0;
            neuron       <= '0;
            drain        <= 1'b0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            rd_en        <= 1'b0;
            mac_forget   <= 1'b0;
            mac_oe       <= 1'b0;
            mac_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            result_idx   <= '0;
        end else begin
            state        <= next_state;
            x_addr       <= state == FETCH ? (last_i ? '0 : x_addr + 1'b1) : x_addr;
            w_addr       <= state == FETCH ? (last_i && last_n ? '0 : w_addr + 1'b1) : w_addr;
            neuron       <= state == READ ? (last_n ? '0 : neuron + 1'b1) : neuron;
            drain        <= state == DRAIN && !drain;
            rd_en        <= next_state == FETCH;
            v1           <= rd_en;
            v2           <= v1;
            // First cycle the MAC's input registers hold pair 0
            mac_forget   <= v1 && !v2;
            mac_oe       <= next_state == READ;
            mac_reset    <= next_state == IDLE;
            busy         <= next_state != IDLE;
            done         <= next_state == DONE;
            result_valid <= state == READ;
            result       <= state == READ ? mac_out : result;
            result_idx   <= state == READ ? neuron : result_idx;
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: scoreboard bench with a behavioural MAC and synchronous memories.
module tb_mac_sequencer;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, hold = 1'b0;
    logic busy, done, rd_en, mac_forget, mac_oe, mac_reset, result_valid;
    logic [2:0] w_addr;
    logic [1:0] x_addr;
    logic [7:0] w_rdata = 8'd0, x_rdata = 8'd0, mac_weight, mac_in, mac_out, result;
    logic [0:0] result_idx;
    logic [7:0] wmem [8];
    logic [7:0] xmem [4];
    logic [7:0] wr, xr, acc;
    logic [8:0] q [$];
    logic [8:0] e;
    int vectors = 0, errors = 0, cyc = 0, t0 = -100, rv_cnt = 0, done_cnt = 0;
    logic prev_rd = 1'b0;

    always #5 clk = ~clk;

    mac_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .w_addr(w_addr), .x_addr(x_addr),
        .w_rdata(w_rdata), .x_rdata(x_rdata),
        .mac_weight(mac_weight), .mac_in(mac_in), .mac_forget(mac_forget),
        .mac_oe(mac_oe), .mac_reset(mac_reset), .mac_out(mac_out),
        .result(result), .result_idx(result_idx), .result_valid(result_valid)
    );

    always @(posedge clk) begin
        w_rdata <= hold ? 8'hFF : rd_en ? wmem[w_addr] : w_rdata;
        x_rdata <= hold ? 8'hFF : rd_en ? xmem[x_addr] : x_rdata;
    end

    // Pipelined MAC: inputs registered, product of the held pair accumulated next cycle
    always @(posedge clk) begin
        if (mac_reset) begin
            wr <= 8'd0; xr <= 8'd0; acc <= 8'd0;
        end else begin
            wr  <= mac_weight;
            xr  <= mac_in;
            acc <= (mac_forget ? 8'd0 : acc) + 8'(wr * xr);
        end
    end
    assign mac_out = mac_oe ? acc : 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (result_valid) begin
            rv_cnt++;
            chk("rv_latency", cyc - t0, 7);
            if (q.size() == 0) begin
                vectors++; errors++;
                $display("FAIL unexpected_result: got %0d idx %0d expected none", result, result_idx);
            end else begin
                e = q.pop_front();
                chk("result", result, e[7:0]);
                chk("result_idx", result_idx, e[8]);
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_with_rv", result_valid, 1);
            chk("done_q_empty", q.size(), 0);
        end
        chk("forget", mac_forget, (cyc == t0 + 2) && reset);
        if (!prev_rd) begin
            chk("mac_weight_zero", mac_weight, 0);
            chk("mac_in_zero", mac_in, 0);
        end
        if (rd_en && !prev_rd) t0 = cyc;
        prev_rd = rd_en;
    end

    task automatic run(input bit poke);
        int n;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_start", busy, 1);
        chk("rd_en_start", rd_en, 1);
        if (poke) begin
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!mac_oe && n < 50);
            chk("poke_read_seen", mac_oe, 1);
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 100);
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic load(input logic [7:0] wa, input logic [7:0] wb, input bit ramp);
        for (int k = 0; k < 8; k++) wmem[k] = k < 4 ? (ramp ? 8'(k + 1) : wa) : wb;
        for (int k = 0; k < 4; k++) xmem[k] = ramp ? 8'(k + 5) : wa;
    endtask

    initial begin
        int rv0, d0;
        load(8'd0, 8'd2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_mac_reset", mac_reset, 1);
        chk("rst_mac_oe", mac_oe, 0);
        chk("rst_result", result, 0);
        chk("rst_result_idx", result_idx, 0);
        chk("rst_result_valid", result_valid, 0);
        @(negedge clk) reset = 1'b1;

        q.push_back({1'b0, 8'd70}); q.push_back({1'b1, 8'd52});
        run(1'b0);

        hold = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("hold_weight", mac_weight, 0);
            chk("hold_in", mac_in, 0);
            chk("hold_rd_en", rd_en, 0);
        end
        hold = 1'b0;
        load(8'd1, 8'd1, 1'b0);
        q.push_back({1'b0, 8'd4}); q.push_back({1'b1, 8'd4});
        run(1'b0);

        load(8'd20, 8'd20, 1'b0);
        q.push_back({1'b0, 8'd64}); q.push_back({1'b1, 8'd64});
        rv0 = rv_cnt; d0 = done_cnt;
        run(1'b1);
        repeat (3) @(negedge clk);
        chk("poke_rv_count", rv_cnt - rv0, 2);
        chk("poke_done_count", done_cnt - d0, 1);
        chk("poke_idle", busy, 0);

        load(8'd0, 8'd2, 1'b1);
        q.push_back({1'b0, 8'd70}); q.push_back({1'b1, 8'd52});
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!result_valid && n < 50);
            chk("abort_rv0_seen", result_valid, 1);
        end
        @(posedge clk); #3 reset = 1'b0;
        q.delete();
        #1;
        chk("abort_mac_reset", mac_reset, 1);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_forget", mac_forget, 0);
        chk("abort_oe", mac_oe, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_still_idle", busy, 0);
        q.push_back({1'b0, 8'd70}); q.push_back({1'b1, 8'd52});
        run(1'b0);
        chk("final_q_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
